// File: rtl/addr_seq_ctrl_pkg.sv
// Shared constants for the dual-rate address sequencer: FSM encoding and perf counter width.
package addr_seq_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t CLEAR = 2'd1;
    localparam state_t RUN   = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int unsigned HOLD_CNT_W = 16;

endpackage

// File: rtl/addr_seq_ctrl_if.sv
// Host-side control bundle of the address sequencer; master = host FSM, slave = sequencer.
interface addr_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 2
);
    logic              Start;
    logic [ADDR_W:0]   Len;
    logic              Hold;
    logic              ClrAddr;
    logic              IncA;
    logic              IncB;
    logic              Busy;
    logic              Done;

    modport master (
        output Start, Len, Hold,
        input  ClrAddr, IncA, IncB, Busy, Done
    );

    modport slave (
        input  Start, Len, Hold,
        output ClrAddr, IncA, IncB, Busy, Done
    );
endinterface

// File: rtl/seq_div_phase.sv
// Beat-phase divider for the slow counter: term is high on the last beat of each DIV_B group.
module seq_div_phase #(
    parameter int unsigned DIV_B = 2
) (
    input  logic clk,
    input  logic Reset,
    input  logic adv,
    input  logic clr,
    output logic term
);
    localparam int unsigned PH_W = (DIV_B > 1) ? $clog2(DIV_B) : 1;
    localparam logic [PH_W-1:0] LAST = PH_W'(DIV_B - 1);

    if (DIV_B < 1 || DIV_B > 16) begin : g_bad_div
        $error("seq_div_phase: DIV_B must be in 1..16");
    end

    logic [PH_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (Reset || clr) begin
            phase <= '0;
        end else if (adv) begin
            phase <= term ? '0 : phase + PH_W'(1);
        end
    end

    assign term = (phase == LAST);

endmodule

// File: rtl/addr_seq_ctrl.sv
// Burst sequencer driving the Inc/Clr pins of the fast (A) and slow (B) address counters.
// Optional ADDR_SEQ_CTRL_PERF_EN adds a saturating HoldCycles stall counter.
module addr_seq_ctrl
    import addr_seq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DIV_B  = 2
) (
    input  logic                  clk,
    input  logic                  Reset,
    addr_seq_ctrl_if.slave        bus
`ifdef ADDR_SEQ_CTRL_PERF_EN
    ,
    output logic [HOLD_CNT_W-1:0] HoldCycles
`endif
);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] beat_cnt;
    logic            start_acc;
    logic            adv;
    logic            last_beat;
    logic            phase_term;

    assign start_acc = (state_q == IDLE) && bus.Start;
    assign adv       = (state_q == RUN) && !bus.Hold;
    // Only evaluated in RUN, where len_q is known to be non-zero.
    assign last_beat = (beat_cnt == len_q - ONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = CLEAR;
            CLEAR:   state_d = (len_q != '0) ? RUN : DONE;
            RUN:     if (adv && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                len_q    <= bus.Len;
                beat_cnt <= '0;
            end else if (adv) begin
                beat_cnt <= beat_cnt + ONE;
            end
        end
    end

    seq_div_phase #(
        .DIV_B (DIV_B)
    ) u_div_phase (
        .clk   (clk),
        .Reset (Reset),
        .adv   (adv),
        .clr   (start_acc),
        .term  (phase_term)
    );

    assign bus.ClrAddr = (state_q == CLEAR);
    assign bus.IncA    = adv;
    assign bus.IncB    = adv && phase_term;
    assign bus.Busy    = (state_q == CLEAR) || (state_q == RUN);
    assign bus.Done    = (state_q == DONE);

`ifdef ADDR_SEQ_CTRL_PERF_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (Reset || start_acc) begin
            hold_cnt <= '0;
        end else if ((state_q == RUN) && bus.Hold && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
        end
    end

    assign HoldCycles = hold_cnt;
`endif

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl: directed burst tables, corner sequences, random vs model.
module tb_addr_seq_ctrl;
    localparam int ADDR_W = 2;
    localparam int DIV_B  = 2;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    addr_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus  ();
    addr_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus3 ();

`ifdef ADDR_SEQ_CTRL_PERF_EN
    logic [15:0] hc, hc3;
`endif

    addr_seq_ctrl #(.ADDR_W(ADDR_W), .DIV_B(DIV_B)) u_dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
`ifdef ADDR_SEQ_CTRL_PERF_EN
        ,
        .HoldCycles (hc)
`endif
    );

    addr_seq_ctrl #(.ADDR_W(ADDR_W), .DIV_B(3)) u_dut3 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus3)
`ifdef ADDR_SEQ_CTRL_PERF_EN
        ,
        .HoldCycles (hc3)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle on the DIV_B=2 unit; o = {ClrAddr, IncA, IncB, Busy, Done}.
    task automatic cyc(input logic st, input logic hd, input logic rs, input logic [2:0] ln,
                       output logic [4:0] o);
        bus.Start = st;
        bus.Hold  = hd;
        bus.Len   = ln;
        Reset     = rs;
        @(negedge clk);
        o = {bus.ClrAddr, bus.IncA, bus.IncB, bus.Busy, bus.Done};
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  len;
        logic [15:0] hold;
        logic [15:0] clr;
        logic [15:0] inca;
        logic [15:0] incb;
        logic [15:0] busy;
        logic [15:0] done;
    } vec_t;

    vec_t vecs[6];

    // Reference model state: burst progress counted in beats.
    int m_stage, m_beats, m_len, m_hold;

    initial begin
        logic [4:0]  o;
        logic [15:0] mc, ma, mb, mbu, md;
        logic [4:0]  exp_o;
        logic        st, hd, rs;
        logic [2:0]  ln;

        vecs[0] = '{3'd4, 16'h0000, 16'h0002, 16'h003C, 16'h0028, 16'h003E, 16'h0040};
        vecs[1] = '{3'd3, 16'h0018, 16'h0002, 16'h0064, 16'h0020, 16'h007E, 16'h0080};
        vecs[2] = '{3'd0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0004};
        vecs[3] = '{3'd1, 16'h0000, 16'h0002, 16'h0004, 16'h0000, 16'h0006, 16'h0008};
        vecs[4] = '{3'd7, 16'h0004, 16'h0002, 16'h03F8, 16'h0150, 16'h03FE, 16'h0400};
        vecs[5] = '{3'd7, 16'h1002, 16'h0002, 16'h01FC, 16'h00A8, 16'h01FE, 16'h0200};

        bus3.Start = 1'b0;
        bus3.Hold  = 1'b0;
        bus3.Len   = '0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b1, 3'd5, o);
        cyc(1'b1, 1'b0, 1'b1, 3'd5, o);
        cyc(1'b0, 1'b1, 1'b1, 3'd5, o);
        check("reset_outputs", int'(o), 0);
`ifdef ADDR_SEQ_CTRL_PERF_EN
        check("reset_holdcycles", int'(hc), 0);
`endif

        // Table of single bursts, Start at cycle 0
        foreach (vecs[i]) begin
            mc = '0; ma = '0; mb = '0; mbu = '0; md = '0;
            for (int c = 0; c < 16; c++) begin
                cyc(c == 0, vecs[i].hold[c], 1'b0, vecs[i].len, o);
                mc[c] = o[4]; ma[c] = o[3]; mb[c] = o[2]; mbu[c] = o[1]; md[c] = o[0];
            end
            check($sformatf("vec%0d_clr", i),  int'(mc),  int'(vecs[i].clr));
            check($sformatf("vec%0d_inca", i), int'(ma),  int'(vecs[i].inca));
            check($sformatf("vec%0d_incb", i), int'(mb),  int'(vecs[i].incb));
            check($sformatf("vec%0d_busy", i), int'(mbu), int'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), int'(md),  int'(vecs[i].done));
            if (i == 0) begin
                check("vec0_cntA_wrap", $countones(ma) % 4, 0);
                check("vec0_cntB", $countones(mb) % 4, 2);
            end
`ifdef ADDR_SEQ_CTRL_PERF_EN
            if (i == 1) check("vec1_holdcycles", int'(hc), 2);
`endif
        end

        // Reset in cycle 4 of a Len=7 burst
        for (int c = 0; c < 8; c++) begin
            cyc(c == 0, 1'b0, c == 4, 3'd7, o);
            if (c == 4) check("midrst_run_before", int'(o[3]), 1);
            if (c >= 5) check($sformatf("midrst_quiet_c%0d", c), int'(o), 0);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd2, o);
        cyc(1'b0, 1'b0, 1'b0, 3'd2, o);
        check("midrst_restart_clr", int'(o), int'(5'b10010));
        for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 1'b0, 3'd2, o);

        // Start held high, Len=2: second CLEAR follows one IDLE cycle after Done
        mc = '0; md = '0; mbu = '0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'd2, o);
            mc[c] = o[4]; md[c] = o[0]; mbu[c] = o[1];
        end
        check("held_start_clr", int'(mc), 16'h0042);
        check("held_start_done", int'(md), 16'h0010);
        check("held_start_busy", int'(mbu), 16'h00CE);
        for (int c = 0; c < 8; c++) cyc(1'b0, 1'b0, 1'b0, 3'd2, o);

        // DIV_B=3, Len=7
        ma = '0; mb = '0;
        bus3.Len = 3'd7;
        for (int c = 0; c < 12; c++) begin
            bus3.Start = (c == 0);
            @(negedge clk);
            ma[c] = bus3.IncA;
            mb[c] = bus3.IncB;
            @(posedge clk);
            #1;
        end
        bus3.Start = 1'b0;
        check("div3_inca_count", $countones(ma), 7);
        check("div3_incb_count", $countones(mb), 2);
        check("div3_incb_pos", int'(mb), 16'h0090);

        // Random stimulus against the beat-level model
        m_stage = 0; m_beats = 0; m_len = 0; m_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom % 4) == 0;
            hd = ($urandom % 3) == 0;
            rs = (n == 0) || (($urandom % 64) == 0);
            ln = 3'($urandom % 8);
            exp_o[4] = (m_stage == 1);
            exp_o[3] = (m_stage == 2) && !hd;
            exp_o[2] = exp_o[3] && (((m_beats + 1) % DIV_B) == 0);
            exp_o[1] = (m_stage == 1) || (m_stage == 2);
            exp_o[0] = (m_stage == 3);
            cyc(st, hd, rs, ln, o);
            if (n > 0) check($sformatf("rand_c%0d", n), int'(o), int'(exp_o));
            if (rs) begin
                m_stage = 0; m_beats = 0; m_len = 0; m_hold = 0;
            end else begin
                case (m_stage)
                    0: if (st) begin m_len = ln; m_beats = 0; m_hold = 0; m_stage = 1; end
                    1: m_stage = (m_len != 0) ? 2 : 3;
                    2: if (!hd) begin
                           m_beats++;
                           if (m_beats == m_len) m_stage = 3;
                       end else if (m_hold < 65535) begin
                           m_hold++;
                       end
                    default: m_stage = 0;
                endcase
            end
`ifdef ADDR_SEQ_CTRL_PERF_EN
            check($sformatf("rand_hc_c%0d", n), int'(hc), m_hold);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
